// File: rtl/gcm_axis_block_detector.sv
// gcm_axis_block_detector: per-stream AXI-Stream stall detector with one report per stall episode
module gcm_axis_block_detector #(
  parameter int NUM_STREAMS  = 7,
  parameter int CNT_W        = 16,
  parameter int STALL_THRESH = 1024,
  parameter int IDX_W        = 3
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [NUM_STREAMS-1:0] tap_tvalid,
  input  logic [NUM_STREAMS-1:0] tap_tready,
  output logic [NUM_STREAMS-1:0] axis_block_sigs,
  output logic                   any_block,
  output logic                   report_valid,
  input  logic                   report_ready,
  output logic [IDX_W-1:0]       report_idx,
  output logic                   report_kind
);
  typedef enum logic [1:0] {S_IDLE, S_REPORT, S_WAIT_CLEAR} state_t;
  localparam logic [CNT_W-1:0] THRESH = CNT_W'(STALL_THRESH);
  state_t                   state_q;
  logic [CNT_W-1:0]         cnt_q [NUM_STREAMS];
  logic [CNT_W-1:0]         cnt_d [NUM_STREAMS];
  logic [NUM_STREAMS-1:0]   kind_q, kind_d, block_q, block_d;
  logic                     any_block_q, report_valid_q, report_kind_q;
  logic [IDX_W-1:0]         report_idx_q, first_idx;
  logic                     first_kind;
  always_comb begin
    kind_d    = kind_q;
    block_d   = '0;
    first_idx = '0;
    first_kind = 1'b0;
    for (int i = 0; i < NUM_STREAMS; i++) begin
      kind_d[i]  = (enable && (tap_tvalid[i] ^ tap_tready[i])) ? tap_tvalid[i] : kind_q[i];
      cnt_d[i]   = (!enable || !(tap_tvalid[i] ^ tap_tready[i])) ? '0 :
                   (tap_tvalid[i] != kind_q[i]) ? CNT_W'(1) :
                   (cnt_q[i] == THRESH) ? THRESH : cnt_q[i] + 1'b1;
      block_d[i] = enable && (tap_tvalid[i] ^ tap_tready[i]) && (cnt_d[i] == THRESH);
    end
    // descending scan leaves the lowest blocked index as the winner
    for (int i = NUM_STREAMS - 1; i >= 0; i--) begin
      if (block_d[i]) begin
        first_idx  = IDX_W'(i);
        first_kind = kind_d[i];
      end
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_STREAMS; i++) cnt_q[i] <= '0;
      kind_q         <= '0;
      block_q        <= '0;
      any_block_q    <= 1'b0;
      report_valid_q <= 1'b0;
      report_idx_q   <= '0;
      report_kind_q  <= 1'b0;
      state_q        <= S_IDLE;
    end else begin
      for (int i = 0; i < NUM_STREAMS; i++) cnt_q[i] <= cnt_d[i];
      kind_q      <= kind_d;
      block_q     <= block_d;
      any_block_q <= |block_d;
      if (!enable) begin
        report_valid_q <= 1'b0;
        state_q        <= S_IDLE;
      end else begin
        case (state_q)
          S_IDLE: if (|block_d) begin
            report_idx_q   <= first_idx;
            report_kind_q  <= first_kind;
            report_valid_q <= 1'b1;
            state_q        <= S_REPORT;
          end
          S_REPORT: if (report_ready) begin
            report_valid_q <= 1'b0;
            state_q        <= S_WAIT_CLEAR;
          end
          S_WAIT_CLEAR: if (block_q == '0) state_q <= S_IDLE;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end
  assign axis_block_sigs = block_q;
  assign any_block       = any_block_q;
  assign report_valid    = report_valid_q;
  assign report_idx      = report_idx_q;
  assign report_kind     = report_kind_q;
endmodule

// File: tb/tb_gcm_axis_block_detector.sv
// tb_gcm_axis_block_detector: directed + random checks against a run-length reference model
module tb_gcm_axis_block_detector;
  localparam int N = 7;
  localparam int T = 4;
  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         enable = 1'b0;
  logic [N-1:0] tap_tvalid = '0, tap_tready = '0;
  logic [N-1:0] axis_block_sigs;
  logic         any_block, report_valid, report_ready = 1'b0, report_kind;
  logic [2:0]   report_idx;
  int           n_vec = 0, n_bad = 0;
  int           run [N];
  logic [N-1:0] m_rk = '0, m_block = '0;
  logic         m_rv = 1'b0, m_kind = 1'b0;
  logic [2:0]   m_idx = '0;
  int           m_phase = 0;

  gcm_axis_block_detector #(.NUM_STREAMS(N), .CNT_W(16), .STALL_THRESH(T), .IDX_W(3)) dut (
    .clock(clock), .reset(reset), .enable(enable), .tap_tvalid(tap_tvalid), .tap_tready(tap_tready),
    .axis_block_sigs(axis_block_sigs), .any_block(any_block), .report_valid(report_valid),
    .report_ready(report_ready), .report_idx(report_idx), .report_kind(report_kind));

  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [12:0] got();
    return {axis_block_sigs, any_block, report_valid, report_idx, report_kind};
  endfunction

  function automatic logic [12:0] want();
    return {m_block, |m_block, m_rv, m_idx, m_kind};
  endfunction

  // Model: a stream is blocked once its current same-direction waiting run reaches T cycles.
  task automatic step(input logic [N-1:0] v, input logic [N-1:0] r, input logic rdy, input logic en, input logic rst);
    logic [N-1:0] prev;
    tap_tvalid = v; tap_tready = r; report_ready = rdy; enable = en; reset = rst;
    @(posedge clock);
    prev = m_block;
    if (rst || !en) begin
      for (int i = 0; i < N; i++) run[i] = 0;
      m_block = '0; m_rv = 1'b0; m_phase = 0;
      if (rst) begin m_rk = '0; m_idx = '0; m_kind = 1'b0; end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (v[i] != r[i]) begin
          if (run[i] > 0 && m_rk[i] == v[i]) run[i]++;
          else begin run[i] = 1; m_rk[i] = v[i]; end
        end else run[i] = 0;
        m_block[i] = run[i] >= T;
      end
      if (m_phase == 0 && m_block != 0) begin
        for (int i = N - 1; i >= 0; i--) if (m_block[i]) begin m_idx = 3'(i); m_kind = m_rk[i]; end
        m_rv = 1'b1; m_phase = 1;
      end else if (m_phase == 1 && rdy) begin
        m_rv = 1'b0; m_phase = 2;
      end else if (m_phase == 2 && prev == 0) m_phase = 0;
    end
    #1;
  endtask

  task automatic test_reset();
    step('0, '0, 1'b0, 1'b0, 1'b1);
    step('0, '0, 1'b0, 1'b0, 1'b1);
    n_vec++;
    if (got() !== 13'h0) begin n_bad++; $display("FAIL reset: got %h want %h", got(), 13'h0); end
    step('0, '0, 1'b1, 1'b1, 1'b0);
    n_vec++;
    if (got() !== want()) begin n_bad++; $display("FAIL reset_idle: got %h want %h", got(), want()); end
  endtask

  task automatic test_single_stall();
    for (int c = 1; c <= T; c++) begin
      step(7'b0000100, '0, 1'b0, 1'b1, 1'b0);
      n_vec++;
      if (got() !== want()) begin n_bad++; $display("FAIL single_stall c%0d: got %h want %h", c, got(), want()); end
    end
    n_vec++;
    if ({axis_block_sigs, report_valid, report_idx, report_kind} !== {7'b0000100, 1'b1, 3'd2, 1'b1}) begin
      n_bad++; $display("FAIL single_stall_T1: got %b/%b/%0d/%b want 0000100/1/2/1", axis_block_sigs, report_valid, report_idx, report_kind);
    end
    for (int c = 0; c < 3; c++) begin
      step('0, '0, 1'b1, 1'b1, 1'b0);
      n_vec++;
      if (got() !== want()) begin n_bad++; $display("FAIL single_clear c%0d: got %h want %h", c, got(), want()); end
    end
  endtask

  task automatic test_interrupted();
    logic seen;
    seen = 1'b0;
    for (int c = 0; c < 7; c++) begin
      step(7'b0000100, (c == 3) ? 7'b0000100 : 7'b0, 1'b1, 1'b1, 1'b0);
      seen |= axis_block_sigs[2] | report_valid;
      n_vec++;
      if (got() !== want()) begin n_bad++; $display("FAIL interrupted c%0d: got %h want %h", c, got(), want()); end
    end
    n_vec++;
    if (seen !== 1'b0) begin n_bad++; $display("FAIL interrupted_T2: block/report seen %b want 0", seen); end
    step('0, '0, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_simultaneous();
    for (int c = 0; c < T; c++) step(7'b0000010, 7'b0010000, 1'b0, 1'b1, 1'b0);
    n_vec++;
    if ({axis_block_sigs, report_valid, report_idx} !== {7'b0010010, 1'b1, 3'd1}) begin
      n_bad++; $display("FAIL simultaneous_T3: got %b/%b/%0d want 0010010/1/1", axis_block_sigs, report_valid, report_idx);
    end
    n_vec++;
    if (got() !== want()) begin n_bad++; $display("FAIL simultaneous_model: got %h want %h", got(), want()); end
  endtask

  task automatic test_backpressure();
    logic [4:0] held;
    held = {report_valid, report_idx, report_kind};
    for (int c = 0; c < 10; c++) begin
      step(7'b0000010, 7'b0000010, 1'b0, 1'b1, 1'b0);
      n_vec++;
      if ({report_valid, report_idx, report_kind} !== held || got() !== want()) begin
        n_bad++; $display("FAIL backpressure c%0d: got %h want %h held %b", c, got(), want(), held);
      end
    end
    step('0, '0, 1'b1, 1'b1, 1'b0);
    n_vec++;
    if (report_valid !== 1'b0) begin n_bad++; $display("FAIL accept: report_valid %b want 0", report_valid); end
    step(7'b1000000, '0, 1'b0, 1'b1, 1'b0);
    for (int c = 1; c < T; c++) step(7'b1000000, '0, 1'b0, 1'b1, 1'b0);
    n_vec++;
    if ({report_valid, report_idx, report_kind} !== {1'b1, 3'd6, 1'b1}) begin
      n_bad++; $display("FAIL rearm_T4: got %b/%0d/%b want 1/6/1", report_valid, report_idx, report_kind);
    end
    step('0, '0, 1'b1, 1'b1, 1'b0);
    step('0, '0, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_kind_change();
    for (int c = 0; c < 2; c++) step(7'b0001000, '0, 1'b0, 1'b1, 1'b0);
    for (int c = 1; c <= T; c++) begin
      step('0, 7'b0001000, 1'b0, 1'b1, 1'b0);
      n_vec++;
      if (got() !== want()) begin n_bad++; $display("FAIL kind_change c%0d: got %h want %h", c, got(), want()); end
    end
    n_vec++;
    if ({axis_block_sigs[3], report_valid, report_idx, report_kind} !== {1'b1, 1'b1, 3'd3, 1'b0}) begin
      n_bad++; $display("FAIL kind_change_T5: got %b/%b/%0d/%b want 1/1/3/0", axis_block_sigs[3], report_valid, report_idx, report_kind);
    end
  endtask

  task automatic test_reset_mid_report();
    step(7'b0001000, '0, 1'b0, 1'b1, 1'b1);
    n_vec++;
    if (got() !== 13'h0) begin n_bad++; $display("FAIL reset_mid_report: got %h want 0", got()); end
    for (int c = 0; c < T; c++) step(7'b0001000, '0, 1'b0, 1'b1, 1'b0);
    n_vec++;
    if ({report_valid, report_idx, report_kind} !== {1'b1, 3'd3, 1'b1} || got() !== want()) begin
      n_bad++; $display("FAIL fresh_report_T6: got %h want %h", got(), want());
    end
  endtask

  task automatic test_enable();
    step(7'b0001000, '0, 1'b0, 1'b0, 1'b0);
    n_vec++;
    if (got() !== {7'b0, 1'b0, 1'b0, report_idx, report_kind} || got() !== want()) begin
      n_bad++; $display("FAIL enable_off: got %h want %h", got(), want());
    end
    for (int c = 1; c < T; c++) step(7'b0001000, '0, 1'b0, 1'b1, 1'b0);
    n_vec++;
    if (report_valid !== 1'b0) begin n_bad++; $display("FAIL enable_restart: report_valid %b want 0", report_valid); end
    step(7'b0001000, '0, 1'b1, 1'b1, 1'b0);
    n_vec++;
    if (got() !== want()) begin n_bad++; $display("FAIL enable_rearm: got %h want %h", got(), want()); end
  endtask

  task automatic test_random();
    logic [N-1:0] v, r;
    v = '0; r = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(9) < 2) v[i] = $urandom_range(1);
        if ($urandom_range(9) < 2) r[i] = $urandom_range(1);
      end
      step(v, r, $urandom_range(3) == 0, $urandom_range(99) != 0, $urandom_range(499) == 0);
      n_vec++;
      if (got() !== want()) begin n_bad++; $display("FAIL random c%0d: got %h want %h", c, got(), want()); end
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) run[i] = 0;
    test_reset();
    test_single_stall();
    test_interrupted();
    test_simultaneous();
    test_backpressure();
    test_kind_change();
    test_reset_mid_report();
    test_enable();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
